uart_rx_param: RTL and testbench

Parametrised UART receiver for the FPGA side of the Bluetooth link. It replaces the fixed 8-bit receiver used between the BT module's TX pin and the command/data parsers. Character width, parity and stop-bit count are configurable, and the line input is synchronised on entry. Each received character is delivered through a valid/ready holding register with framing, parity, break and overrun status.

---
 rtl/uart_rx_param.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop input synchroniser, configurable width/stop bits,
// valid/ready holding register with framing/parity/break/overrun status. Parity: UART_RX_PARITY_EN.
module uart_rx_param #(
  parameter int DATA_BITS = 8,
  parameter int CPB_W     = 12,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CPB_W-1:0]     cycles_per_bit,
  input  logic [1:0]           parity_mode,
  input  logic                 rx_line,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 break_det,
  output logic                 overrun,
  output logic                 busy
);

  localparam int BCW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DELIVER, S_WAIT_HIGH
  } state_t;

  state_t state, state_next;

  logic                 sync1, sync2, rx_s;
  logic [CPB_W-1:0]     cpb_l, timer;
  logic [BCW-1:0]       bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 fe_acc, stop_all_low;
  logic                 cpb_ok, start_go, mid_hit, bit_hit, last_bit, last_stop, sample;
  logic                 load, break_calc;
  logic                 par_active, par_bit_low;

  // Synchroniser flops reset to the idle level so leaving reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop see the pre-edge value of its source.
      sync1 <= rx_line;
      sync2 <= sync1;
    end
  end
  assign rx_s = sync2;

  assign cpb_ok    = cycles_per_bit >= CPB_W'(4);
  assign mid_hit   = timer == (cpb_l >> 1);
  assign bit_hit   = timer == cpb_l - CPB_W'(1);
  assign last_bit  = bit_cnt == BCW'(DATA_BITS - 1);
  assign last_stop = stop_cnt == 1'(STOP_BITS - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      S_IDLE:      if (start_go) state_next = S_START;
      S_START:     if (mid_hit) state_next = rx_s ? S_IDLE : S_DATA;
      S_DATA:      if (bit_hit && last_bit) state_next = par_active ? S_PARITY : S_STOP;
      S_PARITY:    if (bit_hit) state_next = S_STOP;
      S_STOP:      if (bit_hit && last_stop) state_next = S_DELIVER;
      S_DELIVER:   state_next = fe_acc ? S_WAIT_HIGH : S_IDLE;
      S_WAIT_HIGH: if (rx_s) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = state != S_IDLE;
    start_go = (state == S_IDLE) && !rx_s && cpb_ok;
    load     = (state == S_DELIVER) && (!rx_valid || rx_ready);
    case (state)
      S_START:                  sample = mid_hit;
      S_DATA, S_PARITY, S_STOP: sample = bit_hit;
      default:                  sample = 1'b0;
    endcase
  end

  // Bit timer restarts on every state change and after each sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                                 timer <= '0;
    else if (state == S_IDLE || state_next != state || sample) timer <= '0;
    else                                                       timer <= timer + CPB_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpb_l        <= '0;
      bit_cnt      <= '0;
      stop_cnt     <= 1'b0;
      shift_reg    <= '0;
      fe_acc       <= 1'b0;
      stop_all_low <= 1'b1;
    end else begin
      if (start_go) begin
        cpb_l        <= cycles_per_bit;
        bit_cnt      <= '0;
        stop_cnt     <= 1'b0;
        fe_acc       <= 1'b0;
        stop_all_low <= 1'b1;
      end
      // Shifting in at the MSB leaves the LSB-first character right-aligned after DATA_BITS samples.
      if (state == S_DATA && bit_hit) begin
        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
        bit_cnt   <= bit_cnt + BCW'(1);
      end
      if (state == S_STOP && bit_hit) begin
        stop_cnt <= ~stop_cnt;
        if (!rx_s) fe_acc       <= 1'b1;
        else       stop_all_low <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic [1:0] par_mode_l;
  logic       par_bit, par_err_calc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_mode_l <= 2'b00;
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (start_go)                     par_mode_l <= parity_mode;
      if (state == S_PARITY && bit_hit) par_bit    <= rx_s;
      if (load)                         parity_err <= par_err_calc;
    end
  end

  assign par_active   = (par_mode_l == 2'b01) || (par_mode_l == 2'b10);
  // Even mode wants XOR(data, parity) = 0, odd mode wants 1; par_mode_l[1] marks odd.
  assign par_err_calc = par_active && ((^shift_reg ^ par_bit) != par_mode_l[1]);
  assign par_bit_low  = !par_active || !par_bit;
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^parity_mode;
  assign par_active         = 1'b0;
  assign par_bit_low        = 1'b1;
  assign parity_err         = 1'b0;
`endif

  assign break_calc = (shift_reg == '0) && par_bit_low && stop_all_low;

  // A full holding register is freed by a same-cycle handshake, so DELIVER may reload it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      break_det <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= (state == S_DELIVER) && rx_valid && !rx_ready;
      if (load) begin
        rx_data   <= shift_reg;
        rx_valid  <= 1'b1;
        frame_err <= fe_acc;
        break_det <= break_calc;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance at cpb=16 and a 5-bit/2-stop instance at cpb=4.
module tb_uart_rx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [11:0] cpb_a, cpb_b;
  logic [1:0]  pmode;
  logic        line_a, line_b, ready_a, ready_b;

  logic [7:0] data_a;
  logic       valid_a, fe_a, pe_a, brk_a, ov_a, busy_a;
  logic [4:0] data_b;
  logic       valid_b, fe_b, pe_b, brk_b, ov_b, busy_b;

  uart_rx_param #(.DATA_BITS(8), .CPB_W(12), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .cycles_per_bit(cpb_a), .parity_mode(pmode),
    .rx_line(line_a), .rx_data(data_a), .rx_valid(valid_a), .rx_ready(ready_a),
    .frame_err(fe_a), .parity_err(pe_a), .break_det(brk_a), .overrun(ov_a), .busy(busy_a)
  );

  uart_rx_param #(.DATA_BITS(5), .CPB_W(12), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .cycles_per_bit(cpb_b), .parity_mode(pmode),
    .rx_line(line_b), .rx_data(data_b), .rx_valid(valid_b), .rx_ready(ready_b),
    .frame_err(fe_b), .parity_err(pe_b), .break_det(brk_b), .overrun(ov_b), .busy(busy_b)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned pcnt = 0;
  int unsigned fall_pc = 0;
  int unsigned rise_pc = 0;
  int unsigned ov_cnt = 0;
  int unsigned busy_cnt = 0;
  int unsigned base;
  logic        prev_valid = 1'b0;

  always @(posedge clk) pcnt <= pcnt + 1;

  // Monitor for instance A: rx_valid rise time, overrun pulses, busy cycles.
  always @(negedge clk) begin
    if (valid_a && !prev_valid) rise_pc = pcnt;
    prev_valid = valid_a;
    if (ov_a)   ov_cnt++;
    if (busy_a) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input bit to_b, input logic v, input int n);
    if (to_b) line_b = v;
    else      line_a = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit to_b, input logic [8:0] data, input int nbits,
                            input bit has_par, input logic par, input logic [1:0] stops,
                            input int nstops, input int cpb);
    if (!to_b) fall_pc = pcnt;
    drive_bit(to_b, 1'b0, cpb);
    for (int i = 0; i < nbits; i++) drive_bit(to_b, data[i], cpb);
    if (has_par) drive_bit(to_b, par, cpb);
    for (int i = 0; i < nstops; i++) drive_bit(to_b, stops[i], cpb);
    drive_bit(to_b, 1'b1, 2 * cpb);
  endtask

  task automatic consume(input bit to_b);
    if (to_b) ready_b = 1'b1;
    else      ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    ready_b = 1'b0;
  endtask

  initial begin
    reset = 1'b1; line_a = 1'b1; line_b = 1'b1; ready_a = 1'b0; ready_b = 1'b0;
    pmode = 2'b00; cpb_a = 12'd16; cpb_b = 12'd4;
    repeat (3) @(negedge clk);
    check("rst_data_a", data_a, 0);
    check("rst_valid_a", valid_a, 0);
    check("rst_flags_a", {fe_a, pe_a, brk_a, ov_a, busy_a}, 0);
    check("rst_b", {data_b, valid_b, fe_b, pe_b, brk_b, ov_b, busy_b}, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 0xA5: 3 (sync+state) + (8 + 9*16) final stop sample + 2 = 157 cycles to rx_valid.
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 2'b01, 1, 16);
    check("a5_latency", rise_pc - fall_pc, 157);
    check("a5_data", data_a, 8'hA5);
    check("a5_valid", valid_a, 1);
    check("a5_flags", {fe_a, pe_a, brk_a}, 0);
    check("a5_busy", busy_a, 0);
    consume(0);
    check("a5_consumed", valid_a, 0);

`ifdef UART_RX_PARITY_EN
    pmode = 2'b01;
    send_frame(0, 9'h007, 8, 1, 1'b0, 2'b01, 1, 16);
    check("par_latency", rise_pc - fall_pc, 173);
    check("even_p0_data", data_a, 8'h07);
    check("even_p0_err", pe_a, 1);
    check("even_p0_fe", fe_a, 0);
    consume(0);
    send_frame(0, 9'h007, 8, 1, 1'b1, 2'b01, 1, 16);
    check("even_p1_err", pe_a, 0);
    consume(0);
    pmode = 2'b10;
    send_frame(0, 9'h007, 8, 1, 1'b0, 2'b01, 1, 16);
    check("odd_p0_err", pe_a, 0);
    consume(0);
    send_frame(0, 9'h007, 8, 1, 1'b1, 2'b01, 1, 16);
    check("odd_p1_err", pe_a, 1);
    check("odd_p1_valid", valid_a, 1);
    consume(0);
`else
    pmode = 2'b01;
    send_frame(0, 9'h007, 8, 0, 1'b0, 2'b01, 1, 16);
    check("nopar_latency", rise_pc - fall_pc, 157);
    check("nopar_data", data_a, 8'h07);
    check("nopar_flags", {fe_a, pe_a, brk_a}, 0);
    consume(0);
`endif
    pmode = 2'b00;

    // cycles_per_bit below 4 must keep the receiver in IDLE.
    cpb_a = 12'd3;
    base = busy_cnt;
    drive_bit(0, 1'b0, 20);
    check("cpb3_no_busy", busy_cnt - base, 0);
    drive_bit(0, 1'b1, 4);
    cpb_a = 12'd16;

    // Break: line low for 12 bit times.
    base = ov_cnt;
    fall_pc = pcnt;
    drive_bit(0, 1'b0, 192);
    check("brk_latency", rise_pc - fall_pc, 157);
    check("brk_det", brk_a, 1);
    check("brk_fe", fe_a, 1);
    check("brk_data", data_a, 0);
    check("brk_busy_low_line", busy_a, 1);
    drive_bit(0, 1'b1, 8);
    check("brk_busy_released", busy_a, 0);
    consume(0);
    repeat (200) @(negedge clk);
    check("brk_no_second", valid_a, 0);
    check("brk_no_overrun", ov_cnt - base, 0);

    // Overrun: second character arrives while the first is still held.
    base = ov_cnt;
    send_frame(0, 9'h011, 8, 0, 1'b0, 2'b01, 1, 16);
    send_frame(0, 9'h022, 8, 0, 1'b0, 2'b01, 1, 16);
    check("ovr_data_kept", data_a, 8'h11);
    check("ovr_valid", valid_a, 1);
    check("ovr_pulses", ov_cnt - base, 1);
    check("ovr_fe", fe_a, 0);
    consume(0);
    check("ovr_consumed", valid_a, 0);

    // 3-cycle glitch: START entered at cycle 3, rejected at the cpb>>1 sample -> 9 busy cycles.
    base = busy_cnt;
    drive_bit(0, 1'b0, 3);
    drive_bit(0, 1'b1, 40);
    check("glitch_busy_cycles", busy_cnt - base, 9);
    check("glitch_no_valid", valid_a, 0);
    check("glitch_idle", busy_a, 0);

    // Reset in the middle of the data bits of 0x3C.
    base = ov_cnt;
    drive_bit(0, 1'b0, 16);
    drive_bit(0, 1'b0, 16);
    drive_bit(0, 1'b0, 16);
    drive_bit(0, 1'b1, 16);
    check("mid_busy", busy_a, 1);
    reset = 1'b1;
    line_a = 1'b1;
    @(negedge clk);
    check("mid_rst_data", data_a, 0);
    check("mid_rst_outs", {valid_a, fe_a, pe_a, brk_a, ov_a, busy_a}, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    send_frame(0, 9'h05A, 8, 0, 1'b0, 2'b01, 1, 16);
    check("post_rst_latency", rise_pc - fall_pc, 157);
    check("post_rst_data", data_a, 8'h5A);
    check("post_rst_fe", fe_a, 0);
    check("post_rst_no_ovr", ov_cnt - base, 0);
    consume(0);

    // 5-bit, 2 stop bits, cpb=4: second stop bit low.
    send_frame(1, 9'h015, 5, 0, 1'b0, 2'b01, 2, 4);
    check("b_valid", valid_b, 1);
    check("b_data", data_b, 5'h15);
    check("b_fe", fe_b, 1);
    check("b_brk", brk_b, 0);
    check("b_busy", busy_b, 0);
    consume(1);
    send_frame(1, 9'h00A, 5, 0, 1'b0, 2'b11, 2, 4);
    check("b_good_data", data_b, 5'h0A);
    check("b_good_fe", fe_b, 0);
    consume(1);
    check("b_consumed", valid_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
